// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared constants and divisor clamp for the programmable clock divider
package clkdiv_pkg;

   localparam int MIN_DIV      = 2;
   localparam int DEFAULT_DIV  = 4;
   localparam int DEFAULT_HIGH = 2;

   // A period shorter than two cycles cannot hold both a high and a low phase.
   function automatic logic [31:0] clamp_div(input logic [31:0] v);
      return (v < 32'(MIN_DIV)) ? 32'(MIN_DIV) : v;
   endfunction

endpackage

// File: rtl/clkdiv_prog.sv
// rtl/clkdiv_prog.sv - programmable clock divider with glitch-free boundary reload
module clkdiv_prog
   import clkdiv_pkg::*;
#(
   parameter int WIDTH        = 16,
   parameter int DEFAULT_DIV  = clkdiv_pkg::DEFAULT_DIV,
   parameter int DEFAULT_HIGH = clkdiv_pkg::DEFAULT_HIGH
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic             sync,
   input  logic             load,
   input  logic [WIDTH-1:0] div_val,
   input  logic [WIDTH-1:0] high_val,
   output logic             load_ack,
   output logic             clk_n,
   output logic             tick,
   output logic             pending
);

   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] div_cur_q, div_cur_d;
   logic [WIDTH-1:0] high_cur_q, high_cur_d;
   logic [WIDTH-1:0] div_sh_q, div_sh_d;
   logic [WIDTH-1:0] high_sh_q, high_sh_d;
   logic             pending_q, pending_d;
   logic             clk_n_q, clk_n_d;
   logic             tick_q, tick_d;
   logic             load_ack_q, load_ack_d;

   logic [WIDTH-1:0] div_clamped;
   logic             last;
   logic             boundary;

   assign div_clamped = WIDTH'(clamp_div(32'(div_val)));
   // div_cur is never below 2, so div_cur-1 cannot wrap.
   assign last        = (count_q == div_cur_q - WIDTH'(1));
   assign boundary    = sync | (en & last);

   always_comb begin
      count_d    = count_q;
      div_cur_d  = div_cur_q;
      high_cur_d = high_cur_q;
      div_sh_d   = div_sh_q;
      high_sh_d  = high_sh_q;
      pending_d  = pending_q;
      clk_n_d    = clk_n_q;
      tick_d     = 1'b0;
      load_ack_d = 1'b0;

      // A same-cycle load takes priority over the older shadowed request.
      if (boundary && (load || pending_q)) begin
         div_cur_d  = load ? div_clamped : div_sh_q;
         high_cur_d = load ? high_val : high_sh_q;
         pending_d  = 1'b0;
         load_ack_d = 1'b1;
      end else if (load) begin
         pending_d  = 1'b1;
      end

      if (load) begin
         div_sh_d  = div_clamped;
         high_sh_d = high_val;
      end

      if (sync) begin
         count_d = '0;
      end else if (en) begin
         count_d = last ? '0 : count_q + WIDTH'(1);
         clk_n_d = (count_q < high_cur_q);
         tick_d  = (count_q == '0);
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         count_q    <= '0;
         div_cur_q  <= WIDTH'(DEFAULT_DIV);
         high_cur_q <= WIDTH'(DEFAULT_HIGH);
         div_sh_q   <= WIDTH'(DEFAULT_DIV);
         high_sh_q  <= WIDTH'(DEFAULT_HIGH);
         pending_q  <= 1'b0;
         clk_n_q    <= 1'b0;
         tick_q     <= 1'b0;
         load_ack_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         div_cur_q  <= div_cur_d;
         high_cur_q <= high_cur_d;
         div_sh_q   <= div_sh_d;
         high_sh_q  <= high_sh_d;
         pending_q  <= pending_d;
         clk_n_q    <= clk_n_d;
         tick_q     <= tick_d;
         load_ack_q <= load_ack_d;
      end
   end

   assign load_ack = load_ack_q;
   assign clk_n    = clk_n_q;
   assign tick     = tick_q;
   assign pending  = pending_q;

endmodule

// File: tb/tb_clkdiv_prog.sv
// tb/tb_clkdiv_prog.sv - self-checking bench for clkdiv_prog
module tb_clkdiv_prog;

   logic        clk = 1'b0;
   logic        clr;
   logic        en;
   logic        sync;
   logic        load;
   logic [15:0] div_val;
   logic [15:0] high_val;
   logic        load_ack;
   logic        clk_n;
   logic        tick;
   logic        pending;

   int checks = 0;
   int errors = 0;

   // reference state: phase within period, active and requested settings
   int   m_phase, m_period, m_high, m_req_period, m_req_high;
   logic m_pend, m_clkn, m_tick, m_ack;

   clkdiv_prog dut (
      .clk      (clk),
      .clr      (clr),
      .en       (en),
      .sync     (sync),
      .load     (load),
      .div_val  (div_val),
      .high_val (high_val),
      .load_ack (load_ack),
      .clk_n    (clk_n),
      .tick     (tick),
      .pending  (pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_period = 4; m_high = 2;
      m_req_period = 4; m_req_high = 2;
      m_pend = 0; m_clkn = 0; m_tick = 0; m_ack = 0;
   endtask

   task automatic model_edge(input logic e, input logic l, input logic s, input int dv, input int hv);
      int  req_p;
      bit  at_end;
      req_p = (dv < 2) ? 2 : dv;
      m_ack = 0;
      if (s) begin
         at_end  = 1;
         m_phase = 0;
         m_tick  = 0;
      end else if (e) begin
         at_end  = (m_phase == m_period - 1);
         m_tick  = (m_phase == 0);
         m_clkn  = (m_phase < m_high);
         m_phase = (m_phase + 1) % m_period;
      end else begin
         at_end = 0;
         m_tick = 0;
      end
      if (at_end && (l || m_pend)) begin
         m_period = l ? req_p : m_req_period;
         m_high   = l ? hv : m_req_high;
         m_pend   = 0;
         m_ack    = 1;
      end else if (l) begin
         m_pend = 1;
      end
      if (l) begin
         m_req_period = req_p;
         m_req_high   = hv;
      end
   endtask

   task automatic step(input logic e, input logic l, input logic s, input int dv, input int hv);
      en = e; load = l; sync = s;
      div_val = 16'(dv); high_val = 16'(hv);
      model_edge(e, l, s, dv, hv);
      @(posedge clk); #1;
      chk("clk_n", int'(clk_n), int'(m_clkn));
      if (!s) chk("tick", int'(tick), int'(m_tick));
      chk("load_ack", int'(load_ack), int'(m_ack));
      chk("pending", int'(pending), int'(m_pend));
      @(negedge clk);
      load = 0; sync = 0;
   endtask

   task automatic run(input int n, output logic [31:0] pat, output int ticks);
      pat = '0; ticks = 0;
      for (int i = 0; i < n; i++) begin
         step(1, 0, 0, 0, 0);
         pat = {pat[30:0], clk_n};
         ticks += int'(tick);
      end
   endtask

   // loads with en=1 and runs until the new values are applied; returns acks seen
   task automatic load_apply(input int dv, input int hv, output int acks);
      int n;
      acks = 0;
      step(1, 1, 0, dv, hv);
      acks += int'(load_ack);
      n = 0;
      while (acks == 0 && n < 20) begin
         step(1, 0, 0, 0, 0);
         acks += int'(load_ack);
         n++;
      end
      chk("apply_timeout", int'(acks > 0), 1);
   endtask

   initial begin
      logic [31:0] pat;
      int          ticks;
      int          acks;

      clr = 1; en = 0; sync = 0; load = 0; div_val = 0; high_val = 0;
      model_reset();
      #12;
      chk("rst_clk_n", int'(clk_n), 0);
      chk("rst_tick", int'(tick), 0);
      chk("rst_load_ack", int'(load_ack), 0);
      chk("rst_pending", int'(pending), 0);
      @(negedge clk);
      clr = 0;

      // defaults 4/2
      run(8, pat, ticks);
      chk("default_wave", int'(pat[7:0]), 8'b11001100);
      chk("default_ticks", ticks, 2);

      // load 6/3 at count=1
      step(1, 0, 0, 0, 0);
      step(1, 1, 0, 6, 3);
      chk("pending_after_load", int'(pending), 1);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      chk("ack_at_wrap", int'(load_ack), 1);
      run(12, pat, ticks);
      chk("div6_wave", int'(pat[11:0]), 12'b111000111000);
      chk("div6_ticks", ticks, 2);

      // two loads before boundary: last wins, one ack
      step(1, 1, 0, 8, 1);
      acks = int'(load_ack);
      load_apply(5, 1, ticks);
      acks += ticks;
      chk("double_load_acks", acks, 1);
      run(10, pat, ticks);
      chk("div5_wave", int'(pat[9:0]), 10'b1000010000);

      // divisor clamp
      load_apply(0, 1, acks);
      run(6, pat, ticks);
      chk("div0_wave", int'(pat[5:0]), 6'b101010);
      chk("div0_ticks", ticks, 3);

      // high 0 and high beyond period
      load_apply(4, 0, acks);
      run(8, pat, ticks);
      chk("high0_wave", int'(pat[7:0]), 0);
      chk("high0_ticks", ticks, 2);
      load_apply(4, 10, acks);
      run(8, pat, ticks);
      chk("high10_wave", int'(pat[7:0]), 8'hFF);
      chk("high10_ticks", ticks, 2);

      // en low mid-period
      load_apply(6, 3, acks);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0);

      // sync with pending load
      step(1, 0, 0, 0, 0);
      step(1, 1, 0, 5, 2);
      chk("pending_before_sync", int'(pending), 1);
      step(1, 0, 1, 0, 0);
      chk("sync_ack", int'(load_ack), 1);
      step(1, 0, 0, 0, 0);
      chk("tick_after_sync", int'(tick), 1);
      for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0);

      // reset while pending
      step(1, 1, 0, 7, 3);
      #2 clr = 1;
      #1;
      chk("clr_pending", int'(pending), 0);
      chk("clr_clk_n", int'(clk_n), 0);
      model_reset();
      @(negedge clk);
      clr = 0;
      run(8, pat, ticks);
      chk("post_clr_wave", int'(pat[7:0]), 8'b11001100);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         step(logic'($urandom_range(3, 0) != 0),
              logic'($urandom_range(9, 0) == 0),
              logic'($urandom_range(29, 0) == 0),
              int'($urandom_range(9, 0)),
              int'($urandom_range(11, 0)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/clkdiv_prog.md
Name: clkdiv_prog

Overview:
- Runtime-programmable, parametrised successor to the fixed divide-by-4 clock divider.
- Produces a divided square wave clk_n with programmable period and high time, plus a one-cycle tick strobe at the start of each period.
- Drives game-speed timing (drop rate per level), display scan and similar periodic enables in the design.
- New divisor and high-time values are loaded through a request/acknowledge handshake and take effect only at a period boundary, so the output never glitches.

Parameters:
- WIDTH, 16, width of the counter, divisor and high-time fields.
- DEFAULT_DIV, 4, divisor active after reset. Must satisfy 2 <= DEFAULT_DIV <= 2^WIDTH-1.
- DEFAULT_HIGH, 2, high time in cycles active after reset.

Ports:
- clk  in  1  system clock.
- clr  in  1  asynchronous active-high reset.
- en  in  1  count enable. When low, all state holds.
- sync  in  1  synchronous phase restart.
- load  in  1  one-cycle request to load div_val and high_val.
- div_val  in  WIDTH  requested period in clk cycles.
- high_val  in  WIDTH  requested high time in clk cycles.
- load_ack  out  1  one-cycle pulse when the new values become active.
- clk_n  out  1  divided output, registered.
- tick  out  1  one-cycle strobe at each period start, registered.
- pending  out  1  a load is captured but not yet applied.

Behaviour:
- Reset values (clr high, asynchronous):
  - count = 0
  - div_cur = DEFAULT_DIV, high_cur = DEFAULT_HIGH
  - shadow registers = the same defaults
  - pending = 0, clk_n = 0, tick = 0, load_ack = 0
- Clamping, applied when values are captured:
  - div_val < 2 is treated as 2.
  - high_val is used as given.
- Each rising edge with en=1:
  - count advances to 0 if count == div_cur-1, otherwise to count+1.
  - clk_n <= (count < high_cur).
  - tick <= (count == 0).
  - All outputs reflect count before the edge, giving one cycle of latency.
- Duty edge cases:
  - high_cur == 0 gives clk_n constantly 0.
  - high_cur >= div_cur gives clk_n constantly 1.
  - tick still pulses once per period in both cases.
- With en=0:
  - count, clk_n and current/shadow values hold.
  - tick and load_ack are 0.
  - load is still captured into the shadow registers.
- Load handshake:
  - load=1 captures the clamped div_val and high_val into the shadow registers and sets pending=1.
  - A second load while pending overwrites the shadow. The last request wins and only one load_ack follows.
- Apply at boundary:
  - Applies on an en=1 edge where count == div_cur-1.
  - If pending, or if load is asserted in this same cycle, then:
    - div_cur/high_cur take the shadow values (the incoming values when load is asserted, which has priority).
    - pending clears.
    - load_ack=1 for one cycle.
  - The new period starts at count = 0 on the next cycle.
- sync=1 (ignores en):
  - count <= 0.
  - Any pending or same-cycle load is applied immediately, with load_ack=1.
  - clk_n and tick are not updated on that edge.
  - The next en=1 edge produces tick=1 and clk_n = (high_cur > 0).
- Reset mid-operation discards any pending load and restores the defaults.
- Arithmetic:
  - Unsigned WIDTH-bit throughout.
  - The comparison count == div_cur-1 must not underflow. This is guaranteed by the clamp.

Decomposition:
- Package clkdiv_pkg holds:
  - the DEFAULT_DIV and DEFAULT_HIGH constants
  - a clamp function for the divisor
  - the MIN_DIV = 2 constant
- No sub-module. The counter, shadow registers and output registers fit in a single module.

Test Plan:
1. Reset then en=1 with defaults:
   - clk_n reads 1,1,0,0 repeating.
   - tick is high on the cycle clk_n first rises, every 4 cycles.
   - load_ack = 0.
2. load with div_val=6, high_val=3 mid-period (count=1):
   - pending=1 until the wrap.
   - load_ack is a single pulse at the wrap edge.
   - Then clk_n reads 1,1,1,0,0,0 and tick has period 6.
3. Two loads before the boundary (div 8 then div 5, high 1):
   - Only one load_ack.
   - Resulting period is 5, clk_n high for 1 cycle.
4. Edge cases:
   - div_val=0 behaves as period 2.
   - high_val=0 gives clk_n stuck at 0 while tick continues.
   - high_val=10 with div 4 gives clk_n stuck at 1.
5. en low for 7 cycles mid-period:
   - count and clk_n hold, tick = 0.
   - Resuming continues the same period with no extra tick.
6. Reset and sync mid-operation:
   - sync with load pending at count=2 gives immediate load_ack and count=0.
   - Next en edge gives tick=1.
   - clr asserted while pending returns pending=0 and restores the default 4/2 waveform.
